// File: rtl/char_buffer_fill_engine.sv
// Write-only fill engine for the text-mode character RAM: streams a constant or an
// incrementing code over the whole screen or a rectangular cell region.
module char_buffer_fill_engine #(
    parameter int COLS     = 80,
    parameter int ROWS     = 32,
    parameter int COL_W    = 7,
    parameter int ROW_W    = 5,
    parameter int DATA_W   = 7,
    parameter int SEQ_BASE = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [DATA_W-1:0]      fillChar,
    input  logic [ROW_W-1:0]       row0,
    input  logic [ROW_W-1:0]       row1,
    input  logic [COL_W-1:0]       col0,
    input  logic [COL_W-1:0]       col1,
    input  logic                   abort,
    input  logic                   wrReady,
    output logic                   wrEn,
    output logic [COL_W+ROW_W-1:0] wrAddr,
    output logic [DATA_W-1:0]      wrData,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [DATA_W-1:0] SEQ_FIRST = DATA_W'(SEQ_BASE);
    localparam logic [31:0]       COLS_U    = 32'(COLS);
    localparam logic [31:0]       ROWS_U    = 32'(ROWS);

    state_t            state;
    logic [COL_W-1:0]  curCol;
    logic [ROW_W-1:0]  curRow;
    logic [COL_W-1:0]  colFirst;
    logic [COL_W-1:0]  colLast;
    logic [ROW_W-1:0]  rowLast;
    logic              seqMode;

    logic [ROW_W-1:0]  reqRow0;
    logic [ROW_W-1:0]  reqRow1;
    logic [COL_W-1:0]  reqCol0;
    logic [COL_W-1:0]  reqCol1;
    logic              reqBad;
    logic              lastBeat;

    // Region requested by the command; full modes ignore the rectangle inputs.
    always_comb begin
        reqRow0 = '0;
        reqRow1 = ROW_LAST;
        reqCol0 = '0;
        reqCol1 = COL_LAST;
        reqBad  = 1'b0;
        if (mode[1]) begin
            reqRow0 = row0;
            reqRow1 = row1;
            reqCol0 = col0;
            reqCol1 = col1;
            reqBad  = (row0 > row1) || (col0 > col1) ||
                      ({{(32-ROW_W){1'b0}}, row1} >= ROWS_U) ||
                      ({{(32-COL_W){1'b0}}, col1} >= COLS_U);
        end
    end

    assign lastBeat = (curCol == colLast) && (curRow == rowLast);
    assign wrAddr   = {curCol, curRow};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            curCol   <= '0;
            curRow   <= '0;
            colFirst <= '0;
            colLast  <= '0;
            rowLast  <= '0;
            seqMode  <= 1'b0;
            wrEn     <= 1'b0;
            wrData   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // abort takes precedence over a coincident start.
                    if (start && !abort) begin
                        if (reqBad) begin
                            err <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            wrEn     <= 1'b1;
                            curCol   <= reqCol0;
                            curRow   <= reqRow0;
                            colFirst <= reqCol0;
                            colLast  <= reqCol1;
                            rowLast  <= reqRow1;
                            seqMode  <= mode[0];
                            wrData   <= mode[0] ? SEQ_FIRST : fillChar;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        wrEn  <= 1'b0;
                    end else if (wrReady) begin
                        if (lastBeat) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            wrEn  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            if (curCol == colLast) begin
                                curCol <= colFirst;
                                curRow <= curRow + ROW_W'(1);
                            end else begin
                                curCol <= curCol + COL_W'(1);
                            end
                            if (seqMode)
                                wrData <= wrData + DATA_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_fill_engine.sv
// Scoreboard bench for char_buffer_fill_engine: directed commands push expected
// beats/done/err events; a negedge monitor pops and compares them.
module tb_char_buffer_fill_engine;

    localparam int KBEAT = 0;
    localparam int KDONE = 1;
    localparam int KERR  = 2;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [6:0]  data;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  mode;
    logic [6:0]  fillChar;
    logic [4:0]  row0;
    logic [4:0]  row1;
    logic [6:0]  col0;
    logic [6:0]  col1;
    logic        abort;
    logic        wrReady;
    logic        wrEn;
    logic [11:0] wrAddr;
    logic [6:0]  wrData;
    logic        busy;
    logic        done;
    logic        err;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lastBeatCyc = -10;

    char_buffer_fill_engine dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .fillChar(fillChar),
        .row0(row0), .row1(row1), .col0(col0), .col1(col1), .abort(abort),
        .wrReady(wrReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: row-major scan, column fastest, address = col*32 + row.
    task automatic pushRegion(input int r0, input int r1, input int c0, input int c1,
                              input bit seq, input logic [6:0] fc,
                              input int maxBeats, input bit withDone);
        int k = 0;
        exp_t e;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                if (maxBeats < 0 || k < maxBeats) begin
                    e.kind = KBEAT;
                    e.addr = 12'(c * 32 + r);
                    e.data = seq ? 7'(k % 128) : fc;
                    expQ.push_back(e);
                end
                k++;
            end
        end
        if (withDone) begin
            e.kind = KDONE; e.addr = '0; e.data = '0;
            expQ.push_back(e);
        end
    endtask

    task automatic pushErr();
        exp_t e;
        e.kind = KERR; e.addr = '0; e.data = '0;
        expQ.push_back(e);
    endtask

    task automatic issue(input logic [1:0] m, input logic [6:0] fc,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [6:0] c0, input logic [6:0] c1);
        mode = m; fillChar = fc; row0 = r0; row1 = r1; col0 = c0; col1 = c1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d events outstanding, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: every handshake, done and err pulse must match the queue head.
    initial begin
        logic       prevStall = 1'b0;
        logic [11:0] prevAddr = '0;
        logic [6:0]  prevData = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (prevStall) begin
                checks++;
                if (wrEn !== 1'b1 || wrAddr !== prevAddr || wrData !== prevData) begin
                    errors++;
                    $display("FAIL stall hold: got en=%0b addr=%0d data=%0h required en=1 addr=%0d data=%0h",
                             wrEn, wrAddr, wrData, prevAddr, prevData);
                end
            end
            if (wrEn === 1'b1 && wrReady === 1'b1) begin
                checks++;
                if (expQ.size() == 0 || expQ[0].kind != KBEAT) begin
                    errors++;
                    $display("FAIL beat: unexpected beat addr=%0d data=%0h, required no beat", wrAddr, wrData);
                end else begin
                    e = expQ.pop_front();
                    if (wrAddr !== e.addr || wrData !== e.data) begin
                        errors++;
                        $display("FAIL beat: got addr=%0d data=%0h required addr=%0d data=%0h",
                                 wrAddr, wrData, e.addr, e.data);
                    end
                    lastBeatCyc = cyc;
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (expQ.size() == 0 || expQ[0].kind != KDONE) begin
                    errors++;
                    $display("FAIL done: unexpected done pulse, required none");
                end else begin
                    void'(expQ.pop_front());
                    if (cyc != lastBeatCyc + 1 || busy !== 1'b0 || wrEn !== 1'b0) begin
                        errors++;
                        $display("FAIL done timing: got lag=%0d busy=%0b wrEn=%0b required lag=1 busy=0 wrEn=0",
                                 cyc - lastBeatCyc, busy, wrEn);
                    end
                end
            end
            if (err === 1'b1) begin
                checks++;
                if (expQ.size() == 0 || expQ[0].kind != KERR) begin
                    errors++;
                    $display("FAIL err: unexpected err pulse, required none");
                end else begin
                    void'(expQ.pop_front());
                end
            end
            prevStall = (wrEn === 1'b1) && (wrReady === 1'b0);
            prevAddr  = wrAddr;
            prevData  = wrData;
        end
    end

    initial begin
        int pat [4] = '{1, 0, 0, 1};
        int i;
        resetn = 1'b0; start = 1'b0; mode = 2'b00; fillChar = '0;
        row0 = '0; row1 = '0; col0 = '0; col1 = '0; abort = 1'b0; wrReady = 1'b1;
        repeat (3) tick();
        check("reset wrEn", 32'(wrEn), 0);
        check("reset wrAddr", 32'(wrAddr), 0);
        check("reset wrData", 32'(wrData), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);
        resetn = 1'b1;
        tick();

        pushRegion(0, 31, 0, 79, 1'b0, 7'h00, -1, 1'b1);
        issue(2'b00, 7'h00, 5'd0, 5'd0, 7'd0, 7'd0);
        check("full start busy", 32'(busy), 1);
        check("full start wrEn", 32'(wrEn), 1);
        check("full start addr", 32'(wrAddr), 0);
        waitDrain("full const", 3000);
        $display("cmd full/const: 2560 beats expected, checks=%0d errors=%0d", checks, errors);

        pushRegion(0, 31, 0, 79, 1'b1, 7'h00, -1, 1'b1);
        issue(2'b01, 7'h33, 5'd0, 5'd0, 7'd0, 7'd0);
        waitDrain("full seq", 3000);
        $display("cmd full/seq: 2560 beats expected, checks=%0d errors=%0d", checks, errors);

        // fillChar changes and a second start during the run must have no effect.
        pushRegion(5, 5, 10, 79, 1'b0, 7'h20, -1, 1'b1);
        issue(2'b10, 7'h20, 5'd5, 5'd5, 7'd10, 7'd79);
        fillChar = 7'h55;
        tick();
        issue(2'b00, 7'h11, 5'd0, 5'd0, 7'd0, 7'd0);
        waitDrain("rect const", 200);
        $display("cmd rect/const row5 cols10..79: 70 beats expected, checks=%0d errors=%0d", checks, errors);

        pushRegion(1, 2, 4, 6, 1'b1, 7'h00, -1, 1'b1);
        issue(2'b11, 7'h00, 5'd1, 5'd2, 7'd4, 7'd6);
        i = 0;
        while (expQ.size() != 0 && i < 100) begin
            wrReady = pat[i % 4] != 0;
            tick();
            i++;
        end
        wrReady = 1'b1;
        waitDrain("rect seq stall", 10);
        $display("cmd rect/seq 2x3 with stalls: 6 beats expected, checks=%0d errors=%0d", checks, errors);

        pushErr();
        issue(2'b10, 7'h00, 5'd6, 5'd5, 7'd0, 7'd3);
        check("err row pulse", 32'(err), 1);
        check("err row wrEn", 32'(wrEn), 0);
        check("err row busy", 32'(busy), 0);
        tick();
        check("err row clear", 32'(err), 0);
        check("err row busy later", 32'(busy), 0);
        waitDrain("err row", 5);
        $display("cmd rect row0>row1: err expected, checks=%0d errors=%0d", checks, errors);

        pushErr();
        issue(2'b11, 7'h00, 5'd0, 5'd1, 7'd0, 7'd80);
        check("err col pulse", 32'(err), 1);
        check("err col wrEn", 32'(wrEn), 0);
        waitDrain("err col", 5);
        $display("cmd rect col1=80: err expected, checks=%0d errors=%0d", checks, errors);

        // Beats 0..10 are written; abort coincides with beat 10.
        pushRegion(0, 31, 0, 79, 1'b0, 7'h41, 11, 1'b0);
        issue(2'b00, 7'h41, 5'd0, 5'd0, 7'd0, 7'd0);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort wrEn", 32'(wrEn), 0);
        check("abort busy", 32'(busy), 0);
        pushRegion(0, 0, 0, 2, 1'b0, 7'h7f, -1, 1'b1);
        issue(2'b10, 7'h7f, 5'd0, 5'd0, 7'd0, 7'd2);
        check("restart wrEn", 32'(wrEn), 1);
        waitDrain("abort restart", 20);
        $display("cmd abort on beat 10 then restart: 11+3 beats expected, checks=%0d errors=%0d", checks, errors);

        abort = 1'b1;
        issue(2'b00, 7'h00, 5'd0, 5'd0, 7'd0, 7'd0);
        abort = 1'b0;
        check("abort+start idle busy", 32'(busy), 0);
        check("abort+start idle wrEn", 32'(wrEn), 0);
        $display("cmd start with abort in IDLE: ignored, checks=%0d errors=%0d", checks, errors);

        // Abort on the only (last) beat: beat counts, done suppressed.
        pushRegion(2, 2, 3, 3, 1'b0, 7'h0a, -1, 1'b0);
        issue(2'b10, 7'h0a, 5'd2, 5'd2, 7'd3, 7'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort last busy", 32'(busy), 0);
        repeat (3) tick();
        waitDrain("abort last", 5);
        $display("cmd abort on last beat: 1 beat, no done, checks=%0d errors=%0d", checks, errors);

        pushRegion(0, 31, 0, 79, 1'b1, 7'h00, 5, 1'b0);
        issue(2'b01, 7'h00, 5'd0, 5'd0, 7'd0, 7'd0);
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        check("midreset wrEn", 32'(wrEn), 0);
        check("midreset wrAddr", 32'(wrAddr), 0);
        check("midreset wrData", 32'(wrData), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset done", 32'(done), 0);
        resetn = 1'b1;
        repeat (3) tick();
        waitDrain("midreset", 5);
        $display("cmd reset mid-fill: outputs cleared, checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
